img_bram_loader: RTL and testbench
==================================

Name: img_bram_loader

Overview:
- Stream-to-BRAM writer that fills the input image BRAM before the inversion engine runs.
- Accepts 32-bit pixel words on an AXI4-Stream slave and writes them to consecutive word addresses through a native BRAM port: byte addresses 0, 4, 8, and so on.
- Pulses done when the frame is stored, and flags TLAST/length mismatches.

Parameters:
- NUM_WORDS, 785, words per frame; byte addresses 0..4*(NUM_WORDS-1), i.e. 0..3136.
- ADDR_STEP, 4, byte address increment per word.

Ports:
- clk  in  1  system clock; also drives clka.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level input; its rising edge arms a frame load.
- s_axis_tdata  in  32  pixel word.
- s_axis_tvalid  in  1  upstream word valid.
- s_axis_tready  out  1  block ready to accept.
- s_axis_tlast  in  1  last word of frame.
- clka  out  1  BRAM clock, equal to clk.
- rsta  out  1  BRAM reset, equal to rst.
- ena  out  1  BRAM enable, tied 1.
- addra  out  32  BRAM byte address (registered).
- dina  out  32  BRAM write data (registered).
- wea  out  4  byte write enables; 4'hF or 4'h0.
- douta  in  32  BRAM read data; unused.
- busy  out  1  high in LOAD and FLUSH.
- done  out  1  one-cycle pulse when the frame is written.
- tlast_err  out  1  sticky flag: TLAST mismatch in the last frame.
- word_count  out  16  words accepted in the current or last frame.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Synchronous, active-high reset rst.
- Reset values:
  - FSM goes to IDLE; start_reg=0.
  - s_axis_tready=0, addra=0, dina=0, wea=0.
  - busy=0, done=0, tlast_err=0, word_count=0.
- Start detection:
  - start_reg <= start each cycle.
  - start_tick = start & ~start_reg.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - tready=0, wea=0.
  - On start_tick: go to LOAD; clear the internal address to 0, word_count to 0 and tlast_err to 0.
- LOAD:
  - tready=1.
  - A beat is accepted when tvalid & tready.
  - On a beat, at the next edge:
    - addra <= addr_int;
    - dina <= tdata;
    - wea <= 4'hF;
    - addr_int += ADDR_STEP;
    - word_count += 1.
  - With no beat, wea <= 0 at the next edge; addra and dina hold.
  - Latency: a write reaches the BRAM port exactly 1 cycle after its handshake.
  - End of frame:
    - Beat with word_count == NUM_WORDS-1 (the final expected word): go to FLUSH. If tlast=0 on that beat, set tlast_err=1.
    - Beat with tlast=1 and word_count < NUM_WORDS-1 (early end): go to FLUSH and set tlast_err=1. The frame is truncated and the remaining BRAM words are untouched.
- FLUSH:
  - tready=0; the final registered write is on the port (wea=4'hF).
  - done=1 for this single cycle.
  - Next state is IDLE, with wea <= 0.
- Outputs:
  - busy=1 in LOAD and FLUSH.
  - word_count and tlast_err hold after done until the next start_tick.
- start_tick in LOAD or FLUSH is ignored; no restart and no counter change.
- Addresses never wrap: the maximum written address is 4*(NUM_WORDS-1).
  - Words beyond NUM_WORDS are not accepted (tready=0 outside LOAD).
  - Upstream words that arrive after the frame ends stay stalled in the upstream source.
- Reset mid-frame: after the reset edge, wea=0 and tready=0 and the FSM is in IDLE. Partially written BRAM contents are left as-is.
- tdata is written unmodified; no width conversion.
- Address arithmetic is 32-bit unsigned.

Test Plan:
- Nominal frame:
  - Stimulus: start rises; tvalid held 1; 785 words with tdata = index; tlast on word 784.
  - Required: BRAM addr 4k holds k for k=0..784; last wea at addra=3136; done pulses once, in the same cycle as that write; word_count=785; tlast_err=0.
- Backpressure and gaps:
  - Stimulus: tvalid toggles randomly at 50%.
  - Required: the same memory image as nominal; wea asserted only in cycles following a handshake; no address skipped or repeated.
- Early TLAST:
  - Stimulus: tlast on word 9.
  - Required: addresses 0..36 written; done fires after the write to 36; word_count=10; tlast_err=1; tready=0 afterwards.
- Missing TLAST:
  - Stimulus: 785 words with tlast=0 throughout.
  - Required: all 785 words written; tlast_err=1; word 786 never accepted (tready=0).
- Start while busy:
  - Stimulus: start toggled again after word 100.
  - Required: no restart; word_count reaches 785; a single done pulse.
- Reset mid-frame:
  - Stimulus: rst=1 for 1 cycle after word 50.
  - Required: the next cycle has wea=0, tready=0, busy=0, word_count=0. A new start then reloads the frame from addr 0 correctly.

Source files
------------

// File: rtl/img_bram_loader.sv
// img_bram_loader: AXI4-Stream slave that writes one frame of 32-bit pixel
// words to consecutive BRAM byte addresses (0, 4, 8, ...), then pulses done.
// TLAST that disagrees with the expected frame length is reported through
// the sticky tlast_err flag.
module img_bram_loader #(
    parameter int NUM_WORDS = 785,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic        clka,
    output logic        rsta,
    output logic        ena,
    output logic [31:0] addra,
    output logic [31:0] dina,
    output logic [3:0]  wea,
    input  logic [31:0] douta,
    output logic        busy,
    output logic        done,
    output logic        tlast_err,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    state_t      state;
    logic        start_reg;
    logic [31:0] addr_int;
    logic        start_tick;
    logic        beat;
    logic        last_word;
    logic        unused_douta;

    // The BRAM port is write-only here; clock and reset pass straight through.
    assign clka         = clk;
    assign rsta         = rst;
    assign ena          = 1'b1;
    assign unused_douta = ^douta;

    assign start_tick = start & ~start_reg;
    assign beat       = s_axis_tvalid & s_axis_tready;
    // word_count still holds the index of the beat being accepted.
    assign last_word  = (word_count == LAST_IDX);

    // Frame FSM with every output registered; tready/busy are set on the
    // transitions so they match the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            start_reg     <= 1'b0;
            addr_int      <= '0;
            s_axis_tready <= 1'b0;
            addra         <= '0;
            dina          <= '0;
            wea           <= 4'h0;
            busy          <= 1'b0;
            done          <= 1'b0;
            tlast_err     <= 1'b0;
            word_count    <= '0;
        end else begin
            start_reg <= start;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    wea <= 4'h0;
                    if (start_tick) begin
                        state         <= LOAD;
                        addr_int      <= '0;
                        word_count    <= '0;
                        tlast_err     <= 1'b0;
                        s_axis_tready <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        addra      <= addr_int;
                        dina       <= s_axis_tdata;
                        wea        <= 4'hF;
                        addr_int   <= addr_int + 32'(ADDR_STEP);
                        word_count <= word_count + 16'd1;
                        // Either the expected length is reached or TLAST
                        // arrives early; both close the frame, and any
                        // disagreement between the two is an error.
                        if (last_word || s_axis_tlast) begin
                            state         <= FLUSH;
                            s_axis_tready <= 1'b0;
                            done          <= 1'b1;
                            if (last_word != s_axis_tlast)
                                tlast_err <= 1'b1;
                        end
                    end else begin
                        wea <= 4'h0;
                    end
                end
                FLUSH: begin
                    // Final write is on the port this cycle; retire it.
                    wea   <= 4'h0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    wea           <= 4'h0;
                    s_axis_tready <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_bram_loader.sv
// Directed bench for img_bram_loader: a scoreboard holds the expected
// {address, data} of every accepted beat and a monitor pops it when the
// write appears on the BRAM port.
module tb_img_bram_loader;

    localparam int NW = 785;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic        clka, rsta, ena;
    logic [31:0] addra, dina;
    logic [3:0]  wea;
    logic [31:0] douta = '0;
    logic        busy, done, tlast_err;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [63:0] sb[$];

    img_bram_loader #(.NUM_WORDS(NW), .ADDR_STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast),
        .clka(clka), .rsta(rsta), .ena(ena), .addra(addra), .dina(dina),
        .wea(wea), .douta(douta),
        .busy(busy), .done(done), .tlast_err(tlast_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Produce a rising edge on start; the FSM enters LOAD on the second edge.
    task automatic begin_frame();
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one word and wait (bounded) for the handshake; push the expected write.
    task automatic send_word(input int idx, input logic [31:0] d, input logic last,
                             input bit gaps, output bit ok);
        bit hs;
        ok = 1'b0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 0) begin
                tvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            hs = tready;
            @(posedge clk); #1;
            if (hs) begin
                ok = 1'b1;
                sb.push_back({32'(idx) * 32'd4, d});
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic run_frame(input int n, input int last_idx, input bit gaps,
                             input int restart_at, input logic [31:0] base);
        bit ok;
        begin_frame();
        for (int i = 0; i < n; i++) begin
            if (i == restart_at) begin
                start = 1'b1;
                repeat (2) @(posedge clk);
                #1 start = 1'b0;
            end
            send_word(i, base + 32'(i), (i == last_idx), gaps, ok);
            chk("handshake", {31'b0, ok}, 32'd1);
            if (!ok) break;
        end
    endtask

    // After a frame: no further beat may be accepted while tvalid is offered.
    task automatic offer_stalled(input string tag);
        tdata  = 32'hDEAD_BEEF;
        tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk(tag, {31'b0, tready}, 32'd0);
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
    endtask

    task automatic post_frame(input string tag, input int exp_cnt, input logic exp_err,
                              input int done_base);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_word_count"}, 32'(word_count), 32'(exp_cnt));
        chk({tag, "_tlast_err"}, {31'b0, tlast_err}, {31'b0, exp_err});
        chk({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_tready"}, {31'b0, tready}, 32'd0);
    endtask

    initial begin
        int db;
        logic [63:0] e;

        // Monitor: every write on the port must match the oldest accepted beat.
        fork
            forever begin
                @(negedge clk);
                if (wea !== 4'h0) begin
                    chk("wea_value", 32'(wea), 32'hF);
                    chk("write_expected", {31'b0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("addra", addra, e[63:32]);
                        chk("dina", dina, e[31:0]);
                        chk("addr_in_range", {31'b0, addra <= 32'(4 * (NW - 1))}, 32'd1);
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    chk("done_with_write", 32'(wea), 32'hF);
                    chk("done_on_last_write", 32'(sb.size()), 32'd0);
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_tready", {31'b0, tready}, 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_addra", addra, 32'd0);
        chk("rst_dina", dina, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_tlast_err", {31'b0, tlast_err}, 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("ena", {31'b0, ena}, 32'd1);

        // Nominal frame, continuous tvalid, tdata = index
        db = done_cnt;
        run_frame(NW, NW - 1, 1'b0, -1, 32'h0);
        post_frame("nominal", NW, 1'b0, db);

        // Random gaps on tvalid
        db = done_cnt;
        run_frame(NW, NW - 1, 1'b1, -1, 32'hA000_0000);
        post_frame("gaps", NW, 1'b0, db);

        // Early TLAST on word 9
        db = done_cnt;
        run_frame(10, 9, 1'b0, -1, 32'h0000_1000);
        post_frame("early", 10, 1'b1, db);
        offer_stalled("early_stall");

        // Missing TLAST: full length without tlast
        db = done_cnt;
        run_frame(NW, -1, 1'b0, -1, 32'h5500_0000);
        post_frame("notlast", NW, 1'b1, db);
        offer_stalled("notlast_stall");

        // Start toggled again mid-frame is ignored; tlast_err cleared by new start
        db = done_cnt;
        run_frame(NW, NW - 1, 1'b0, 100, 32'h7700_0000);
        post_frame("restart", NW, 1'b0, db);

        // Reset after word 50
        db = done_cnt;
        run_frame(51, -1, 1'b0, -1, 32'h3300_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_wea", 32'(wea), 32'd0);
        chk("midrst_tready", {31'b0, tready}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_sb", 32'(sb.size()), 32'd0);
        chk("midrst_no_done", 32'(done_cnt - db), 32'd0);

        // Reload from address 0 after the reset
        db = done_cnt;
        run_frame(NW, NW - 1, 1'b0, -1, 32'h4400_0000);
        post_frame("reload", NW, 1'b0, db);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
